hh_spike_monitor: RTL and testbench
===================================

Name: hh_spike_monitor

Overview:
Receive side of the neuron output interface. Consumes the spike line and the 8-bit membrane state produced by the HH neuron core. Reports three measurements:
- spike count per fixed window (firing rate)
- inter-spike interval (ISI) in clock cycles
- peak membrane state per window

Sits beside the neuron core, feeding the readout/display path for on-chip characterisation of the neuron.

Parameters:
WINDOW_CYCLES, 1024, rate-window length in clk cycles (>=2)
CNT_W, 8, width of spike count / rate_out
ISI_W, 16, width of ISI counter / isi_out

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
spike_in  in  1  neuron spike level, synchronous to clk
state_in  in  8  neuron membrane state, unsigned
rate_out  out  CNT_W  spikes counted in last completed window
rate_valid  out  1  one-cycle pulse when rate_out/vpeak_out update
vpeak_out  out  8  max state_in seen in last completed window
isi_out  out  ISI_W  cycles between last two spike edges
isi_valid  out  1  one-cycle pulse when isi_out updates
isi_ovf  out  1  last reported ISI saturated
first_seen  out  1  at least one spike edge since reset

Behaviour:
- One clock, clk. rst is synchronous, active-high. While rst=1 at a clk edge, all registers and outputs are 0, including spike_q, the FSM (-> WAIT_FIRST) and the window counter.
- Edge detect: spike_q <= spike_in. edge = spike_in & ~spike_q (combinational). A level held N cycles counts once.
  - spike_q resets to 0, so spike_in=1 on the first cycle after reset counts as an edge.
- Window counter wcnt:
  - Counts 0..WINDOW_CYCLES-1, then wraps to 0.
  - Terminal cycle is wcnt==WINDOW_CYCLES-1.
- Spike counter scnt:
  - Increments on edge and saturates at 2^CNT_W-1.
  - An edge in the terminal cycle belongs to the closing window.
  - Next cycle: rate_out <= scnt + edge (saturated), rate_valid=1 for exactly one cycle, scnt <= 0.
- Peak tracker vmax:
  - vmax <= max(vmax, state_in) each cycle.
  - At terminal: vpeak_out <= max(vmax, state_in), and vmax <= 0.
  - vpeak_out and rate_out update in the same cycle.
- Output latency: rate_out, vpeak_out and isi_out are registered. They are held between updates.
- ISI FSM, two states:
  - WAIT_FIRST: on edge -> RUN; first_seen <= 1; icnt <= 0; no isi_valid.
  - RUN:
    - Each non-edge cycle, icnt <= icnt+1, saturating at 2^ISI_W-1.
    - On edge: isi_out <= sat(icnt+1) = cycle distance between edges; isi_ovf <= (icnt+1 >= 2^ISI_W-1); isi_valid=1 for one cycle; icnt <= 0.
    - Stays in RUN until rst.
- Example: edges at cycles 10 and 17 give isi_out=7.
- Simultaneous events: window terminal and ISI edge in the same cycle are independent. Both valid pulses may assert together.
- rst mid-window: partial window discarded; rate_valid does not fire for it; the next window starts at wcnt=0 on the cycle after rst deasserts.
- No backpressure. Consumers must sample outputs on the valid pulses.

Decomposition:
- Package hh_mon_pkg:
  - default widths (CNT_W, ISI_W)
  - enum isi_state_t {WAIT_FIRST, RUN}
  - saturating-add helper function
- Sub-module sat_counter: parameter W; ports clk, rst, clr, inc, q, at_max.
  - Instantiated for scnt and icnt.
- Window counter and peak tracker stay in the top.

Test Plan (WINDOW_CYCLES=16, CNT_W=8, ISI_W=4 unless noted):
1. Reset: hold rst=1 for 3 cycles with spike_in toggling -> every output is 0, no valid pulses, first_seen=0.
2. Level vs edge: spike_in high for 5 consecutive cycles inside one window -> rate_out=1 at window end.
3. Rate: single-cycle spikes every 4 cycles, starting at wcnt=0 -> rate_valid pulses every 16 cycles with rate_out=4. Add an extra edge at wcnt=15 -> that window reports 5 and the next starts from 0.
4. ISI: edges at cycles 10 and 17 after reset release -> no isi_valid on the first edge; isi_out=7, isi_valid=1 for one cycle, isi_ovf=0 on the second.
5. ISI saturation: edges 20 cycles apart -> isi_out=15, isi_ovf=1. A following gap of 3 gives isi_out=3, isi_ovf=0.
6. Peak plus reset mid-window: state_in ramps 0..200 then falls; expect vpeak_out=200. Assert rst at wcnt=8 -> no rate_valid for the aborted window; the next rate_valid comes 16 cycles after rst release.

Source files
------------

// File: rtl/hh_mon_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | hh_mon_pkg : shared widths, ISI FSM states, saturating-add helper    |
// | Revision   : 1.0                                                     |
// +----------------------------------------------------------------------+
package hh_mon_pkg;

  localparam int DEF_CNT_W = 8;
  localparam int DEF_ISI_W = 16;

  typedef enum logic [0:0] {
    WAIT_FIRST = 1'b0,
    RUN        = 1'b1
  } isi_state_t;

  // Add two values and clamp the result to the all-ones value of a w-bit field.
  function automatic logic [31:0] sat_add(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input int unsigned w);
    logic [32:0] sum;
    logic [32:0] lim;
    sum = {1'b0, a} + {1'b0, b};
    lim = (33'd1 << w) - 33'd1;
    return (sum > lim) ? lim[31:0] : sum[31:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/hh_spike_monitor_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | hh_spike_monitor_if : neuron output bus into the spike monitor       |
// | Revision            : 1.0                                            |
// +----------------------------------------------------------------------+
interface hh_spike_monitor_if
  import hh_mon_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W,
  parameter int ISI_W = DEF_ISI_W
);
  logic             spike_in;
  logic [7:0]       state_in;
  logic [CNT_W-1:0] rate_out;
  logic             rate_valid;
  logic [7:0]       vpeak_out;
  logic [ISI_W-1:0] isi_out;
  logic             isi_valid;
  logic             isi_ovf;
  logic             first_seen;

  modport master (
    output spike_in, state_in,
    input  rate_out, rate_valid, vpeak_out, isi_out, isi_valid, isi_ovf, first_seen
  );

  modport slave (
    input  spike_in, state_in,
    output rate_out, rate_valid, vpeak_out, isi_out, isi_valid, isi_ovf, first_seen
  );
endinterface
`default_nettype wire

// File: rtl/hh_spike_monitor_sat_counter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sat_counter : W-bit up counter, clear has priority, sticks at max    |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q,
  output logic         at_max
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  assign at_max = &cnt_q;
  assign q      = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && !at_max) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/hh_spike_monitor.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | hh_spike_monitor : windowed spike rate, peak membrane state and ISI  |
// | Revision         : 1.0                                               |
// +----------------------------------------------------------------------+
module hh_spike_monitor
  import hh_mon_pkg::*;
#(
  parameter int WINDOW_CYCLES = 1024,
  parameter int CNT_W         = DEF_CNT_W,
  parameter int ISI_W         = DEF_ISI_W
) (
  input  logic                clk,
  input  logic                rst,
  hh_spike_monitor_if.slave   mon
);

  localparam int                WCNT_W  = (WINDOW_CYCLES > 2) ? $clog2(WINDOW_CYCLES) : 1;
  localparam logic [WCNT_W-1:0] WLAST   = WCNT_W'(WINDOW_CYCLES - 1);
  localparam logic [ISI_W-1:0]  ISI_MAX = '1;

  logic              spike_q;
  logic              spike_edge;
  logic [WCNT_W-1:0] wcnt_q;
  logic [WCNT_W-1:0] wcnt_d;
  logic              win_last;

  logic [CNT_W-1:0]  scnt;
  logic              scnt_at_max;
  logic [CNT_W-1:0]  rate_d;
  logic [CNT_W-1:0]  rate_q;
  logic              rate_valid_q;

  logic [7:0]        vmax_q;
  logic [7:0]        vnow;
  logic [7:0]        vpeak_q;

  isi_state_t        state_q;
  isi_state_t        state_d;
  logic              icnt_clr;
  logic              icnt_inc;
  logic              isi_fire;
  logic              first_set;
  logic [ISI_W-1:0]  icnt;
  logic              icnt_at_max;
  logic [ISI_W-1:0]  isi_d;
  logic              isi_ovf_d;
  logic [ISI_W-1:0]  isi_q;
  logic              isi_ovf_q;
  logic              isi_valid_q;
  logic              first_seen_q;

  assign spike_edge = mon.spike_in & ~spike_q;
  assign win_last   = (wcnt_q == WLAST);
  assign wcnt_d     = win_last ? '0 : wcnt_q + 1'b1;

  // An edge landing in the terminal cycle still belongs to the closing window.
  sat_counter #(.W(CNT_W)) u_scnt (
    .clk    (clk),
    .rst    (rst),
    .clr    (win_last),
    .inc    (spike_edge),
    .q      (scnt),
    .at_max (scnt_at_max)
  );

  assign rate_d = (spike_edge && !scnt_at_max) ? scnt + 1'b1 : scnt;
  assign vnow   = (mon.state_in > vmax_q) ? mon.state_in : vmax_q;

  sat_counter #(.W(ISI_W)) u_icnt (
    .clk    (clk),
    .rst    (rst),
    .clr    (icnt_clr),
    .inc    (icnt_inc),
    .q      (icnt),
    .at_max (icnt_at_max)
  );

  assign isi_d     = ISI_W'(sat_add(32'(icnt), 32'd1, ISI_W));
  assign isi_ovf_d = icnt_at_max | (icnt == ISI_MAX - 1'b1);

  always_comb begin
    state_d   = state_q;
    icnt_clr  = 1'b0;
    icnt_inc  = 1'b0;
    isi_fire  = 1'b0;
    first_set = 1'b0;
    unique case (state_q)
      WAIT_FIRST: begin
        if (spike_edge) begin
          state_d   = RUN;
          first_set = 1'b1;
          icnt_clr  = 1'b1;
        end
      end
      RUN: begin
        if (spike_edge) begin
          isi_fire = 1'b1;
          icnt_clr = 1'b1;
        end else begin
          icnt_inc = 1'b1;
        end
      end
      default: state_d = WAIT_FIRST;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      spike_q      <= 1'b0;
      wcnt_q       <= '0;
      vmax_q       <= '0;
      rate_q       <= '0;
      vpeak_q      <= '0;
      rate_valid_q <= 1'b0;
      state_q      <= WAIT_FIRST;
      isi_q        <= '0;
      isi_ovf_q    <= 1'b0;
      isi_valid_q  <= 1'b0;
      first_seen_q <= 1'b0;
    end else begin
      spike_q      <= mon.spike_in;
      wcnt_q       <= wcnt_d;
      vmax_q       <= win_last ? 8'd0 : vnow;
      rate_valid_q <= win_last;
      if (win_last) begin
        rate_q  <= rate_d;
        vpeak_q <= vnow;
      end
      state_q     <= state_d;
      isi_valid_q <= isi_fire;
      if (isi_fire) begin
        isi_q     <= isi_d;
        isi_ovf_q <= isi_ovf_d;
      end
      if (first_set) begin
        first_seen_q <= 1'b1;
      end
    end
  end

  assign mon.rate_out   = rate_q;
  assign mon.rate_valid = rate_valid_q;
  assign mon.vpeak_out  = vpeak_q;
  assign mon.isi_out    = isi_q;
  assign mon.isi_valid  = isi_valid_q;
  assign mon.isi_ovf    = isi_ovf_q;
  assign mon.first_seen = first_seen_q;

endmodule
`default_nettype wire

// File: tb/tb_hh_spike_monitor.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_hh_spike_monitor : directed + random bench with reference model   |
// | Revision            : 1.0                                            |
// +----------------------------------------------------------------------+
module tb_hh_spike_monitor;

  localparam int WIN   = 16;
  localparam int CNT_W = 8;
  localparam int ISI_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;
  localparam int IMAX  = (1 << ISI_W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  hh_spike_monitor_if #(.CNT_W(CNT_W), .ISI_W(ISI_W)) mon ();

  hh_spike_monitor #(
    .WINDOW_CYCLES (WIN),
    .CNT_W         (CNT_W),
    .ISI_W         (ISI_W)
  ) u_dut (
    .clk (clk),
    .rst (rst),
    .mon (mon)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: cycle index since reset release, edge timestamps.
  int m_prev, m_cyc, m_cnt, m_peak, m_seen, m_last;
  int e_rate, e_rv, e_vpeak, e_isi, e_iv, e_ovf, e_first;

  // Values captured from the DUT on its valid pulses.
  int cap_rate, cap_vpeak, cap_isi, cap_ovf;
  int n_rate_pulses, n_isi_pulses;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0d exp=%0d @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_update(input logic r, input logic s, input int st);
    int e, pos, d;
    if (r) begin
      m_prev = 0; m_cyc = 0; m_cnt = 0; m_peak = 0; m_seen = 0; m_last = 0;
      e_rate = 0; e_rv = 0; e_vpeak = 0; e_isi = 0; e_iv = 0; e_ovf = 0; e_first = 0;
      return;
    end
    e      = (s && !m_prev) ? 1 : 0;
    m_prev = s ? 1 : 0;
    pos    = m_cyc % WIN;
    m_cnt  = (m_cnt + e > CMAX) ? CMAX : m_cnt + e;
    m_peak = (st > m_peak) ? st : m_peak;
    e_rv   = 0;
    if (pos == WIN - 1) begin
      e_rate  = m_cnt;
      e_vpeak = m_peak;
      e_rv    = 1;
      m_cnt   = 0;
      m_peak  = 0;
    end
    e_iv = 0;
    if (e == 1) begin
      if (m_seen == 1) begin
        d     = m_cyc - m_last;
        e_isi = (d > IMAX) ? IMAX : d;
        e_ovf = (d >= IMAX) ? 1 : 0;
        e_iv  = 1;
      end
      m_seen  = 1;
      e_first = 1;
      m_last  = m_cyc;
    end
    m_cyc++;
  endtask

  task automatic step(input logic r, input logic s, input logic [7:0] st);
    rst          = r;
    mon.spike_in = s;
    mon.state_in = st;
    @(posedge clk);
    model_update(r, s, int'(st));
    #1;
    chk("rate_out",   32'(mon.rate_out),   e_rate);
    chk("rate_valid", 32'(mon.rate_valid), e_rv);
    chk("vpeak_out",  32'(mon.vpeak_out),  e_vpeak);
    chk("isi_out",    32'(mon.isi_out),    e_isi);
    chk("isi_valid",  32'(mon.isi_valid),  e_iv);
    chk("isi_ovf",    32'(mon.isi_ovf),    e_ovf);
    chk("first_seen", 32'(mon.first_seen), e_first);
    if (mon.rate_valid) begin
      cap_rate  = int'(mon.rate_out);
      cap_vpeak = int'(mon.vpeak_out);
      n_rate_pulses++;
    end
    if (mon.isi_valid) begin
      cap_isi = int'(mon.isi_out);
      cap_ovf = int'(mon.isi_ovf);
      n_isi_pulses++;
    end
  endtask

  function automatic logic [7:0] ramp(input int c);
    return (c <= 8) ? 8'(c * 25) : 8'(200 - (c - 8) * 20);
  endfunction

  initial begin
    int k;
    int pct;
    mon.spike_in = 1'b0;
    mon.state_in = 8'd0;
    n_rate_pulses = 0;
    n_isi_pulses  = 0;

    // Reset with a toggling spike line
    for (int i = 0; i < 3; i++) step(1'b1, i[0], 8'(i * 50 + 7));
    chk("rst_pulses", 32'(n_rate_pulses + n_isi_pulses), 0);
    chk("rst_first_seen", 32'(mon.first_seen), 0);

    // Level held five cycles counts once
    for (int c = 0; c < WIN; c++) step(1'b0, (c >= 2 && c <= 6), 8'd10);
    chk("level_rate", 32'(cap_rate), 1);

    // Spikes every 4 cycles, extra edge at the terminal cycle in window 2
    for (int w = 0; w < 4; w++) begin
      for (int p = 0; p < WIN; p++) begin
        logic s;
        if (w == 3) s = (p % 4 == 0) && (p != 0);
        else        s = (p % 4 == 0) || (w == 2 && p == WIN - 1);
        step(1'b0, s, 8'(p));
      end
      chk("rate_window", 32'(cap_rate), (w == 2) ? 5 : (w == 3) ? 3 : 4);
    end

    // ISI after a fresh reset: edges at 10, 17, 37, 40
    step(1'b1, 1'b0, 8'd0);
    step(1'b1, 1'b0, 8'd0);
    n_isi_pulses = 0;
    for (int c = 0; c <= 41; c++) begin
      step(1'b0, (c == 10 || c == 17 || c == 37 || c == 40), 8'd0);
      if (c == 10) chk("isi_first_none", 32'(n_isi_pulses), 0);
      if (c == 17) begin
        chk("isi_7", 32'(cap_isi), 7);
        chk("isi_7_ovf", 32'(cap_ovf), 0);
        chk("isi_7_pulse", 32'(mon.isi_valid), 1);
      end
      if (c == 18) chk("isi_pulse_width", 32'(mon.isi_valid), 0);
      if (c == 37) begin
        chk("isi_sat", 32'(cap_isi), 15);
        chk("isi_sat_ovf", 32'(cap_ovf), 1);
      end
      if (c == 40) begin
        chk("isi_3", 32'(cap_isi), 3);
        chk("isi_3_ovf", 32'(cap_ovf), 0);
      end
    end

    // Peak tracking, then reset in the middle of a window
    step(1'b1, 1'b0, 8'd0);
    for (int c = 0; c < WIN; c++) step(1'b0, 1'b0, ramp(c));
    chk("vpeak_200", 32'(cap_vpeak), 200);
    for (int c = 0; c < 8; c++) step(1'b0, 1'b0, ramp(c));
    n_rate_pulses = 0;
    step(1'b1, 1'b0, 8'd250);
    k = -1;
    for (int c = 1; c <= 40; c++) begin
      step(1'b0, 1'b0, 8'(c));
      if (mon.rate_valid) begin
        k = c;
        break;
      end
    end
    chk("rst_window_len", 32'(k), 16);
    chk("rst_pulses_once", 32'(n_rate_pulses), 1);
    chk("rst_vpeak", 32'(cap_vpeak), 16);

    // Randomised traffic with sparse resets and varying spike density
    for (int seg = 0; seg < 6; seg++) begin
      pct = (seg % 3 == 0) ? 2 : (seg % 3 == 1) ? 8 : 30;
      for (int c = 0; c < 100; c++) begin
        step(($urandom_range(0, 149) == 0),
             ($urandom_range(0, pct) == 0),
             8'($urandom_range(0, 255)));
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
